// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sine/cosine block.
// Holds the FSM state enum, high-precision PI constants, the gain K and the table depth.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int MAX_ITERS = 32;
    localparam int CNT_W     = 5;

    // PI and PI/2 as Q2.60 words; scaled down to the datapath format on use.
    localparam int          Q_REF       = 60;
    localparam logic [63:0] PI_Q60      = 64'h3243F6A8885A308D;
    localparam logic [63:0] PI_HALF_Q60 = 64'h1921FB54442D1846;

    // CORDIC gain compensation, preloaded into x so no final multiply is needed.
    localparam real K_GAIN = 0.6072529350;

    // Round a Q2.60 constant to Q2.frac (frac < 60).
    function automatic logic [63:0] q2_const(input logic [63:0] v, input int frac);
        logic [63:0] r;
        r = v + (64'd1 << (Q_REF - frac - 1));
        return r >> (Q_REF - frac);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan_o = atan(2^-idx_i) in Q2.(WIDTH-3+GUARD).
// Ports: idx_i (iteration index), atan_o (signed angle, WIDTH+GUARD bits).
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int GUARD = 2
) (
    input  logic [CNT_W-1:0]               idx_i,
    output logic signed [WIDTH+GUARD-1:0] atan_o
);

    localparam int ZW   = WIDTH + GUARD;
    localparam int FRAC = WIDTH - 3 + GUARD;

    logic signed [ZW-1:0] lut [MAX_ITERS];

    // Table contents are fixed at elaboration from the parameters.
    for (genvar k = 0; k < MAX_ITERS; k++) begin : g_lut
        localparam longint VAL = longint'($atan(2.0 ** (-k)) * (2.0 ** FRAC));
        assign lut[k] = $signed(VAL[ZW-1:0]);
    end

    assign atan_o = lut[idx_i];

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative (one micro-rotation per cycle) CORDIC computing cos/sin of an angle.
// Ports: clk, reset_n (async low); in_valid/in_ready + angle_in (Q2.(W-3) rad);
//        out_valid/out_ready + cos_out/sin_out (Q1.(W-2)).
module cordic_sincos_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int ITERS = 20,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] angle_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out
);

    localparam int ZW = WIDTH + GUARD;
    localparam int FA = WIDTH - 3;
    localparam int FZ = FA + GUARD;

    localparam logic [63:0] PI_HALF_A64 = q2_const(PI_HALF_Q60, FA);
    localparam logic [63:0] PI_Z64      = q2_const(PI_Q60, FZ);

    localparam logic signed [WIDTH-1:0] PI_HALF_A = $signed(PI_HALF_A64[WIDTH-1:0]);
    localparam logic signed [ZW-1:0]    PI_Z      = $signed(PI_Z64[ZW-1:0]);

    localparam longint               X0_L = longint'(K_GAIN * (2.0 ** (WIDTH - 2 + GUARD)));
    localparam logic signed [ZW-1:0] X0   = $signed(X0_L[ZW-1:0]);

    localparam logic signed [ZW+1:0] RND = (ZW+2)'((2 ** GUARD) / 2);
    localparam logic signed [ZW+1:0] LIM = (ZW+2)'(2 ** (WIDTH - 2));

    state_t state_q, state_d;

    logic signed [ZW-1:0]    x_q, x_d;
    logic signed [ZW-1:0]    y_q, y_d;
    logic signed [ZW-1:0]    z_q, z_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;
    logic signed [WIDTH-1:0] sin_q, sin_d;

    logic                 last;
    logic                 fold_hi;
    logic                 fold_lo;
    logic                 d_neg;
    logic signed [ZW-1:0] ang_z;
    logic signed [ZW-1:0] z0;
    logic signed [ZW-1:0] xs;
    logic signed [ZW-1:0] ys;
    logic signed [ZW-1:0] atan_w;
    logic signed [ZW-1:0] x_inc;
    logic signed [ZW-1:0] y_inc;
    logic signed [ZW-1:0] z_inc;

    cordic_atan_rom #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) u_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_w)
    );

    // Drop guard bits (round half up), restore quadrant sign, clamp to +-1.0.
    function automatic logic signed [WIDTH-1:0] round_out(
        input logic signed [ZW-1:0] v,
        input logic                 neg
    );
        logic signed [ZW+1:0] r;
        r = ((ZW+2)'(v) + RND) >>> GUARD;
        if (neg) r = -r;
        if (r > LIM) r = LIM;
        else if (r < -LIM) r = -LIM;
        return r[WIDTH-1:0];
    endfunction

    assign last = (cnt_q == CNT_W'(ITERS));

    // Fold into [-pi/2, pi/2]; cos and sin both flip sign under a pi shift.
    assign fold_hi = (angle_in > PI_HALF_A);
    assign fold_lo = (angle_in < -PI_HALF_A);
    assign ang_z   = ZW'(angle_in) <<< GUARD;
    assign z0      = fold_hi ? ang_z - PI_Z :
                     fold_lo ? ang_z + PI_Z : ang_z;

    // One shared add/shift set; d = -1 when z is negative.
    assign d_neg = z_q[ZW-1];
    assign xs    = x_q >>> cnt_q;
    assign ys    = y_q >>> cnt_q;
    assign x_inc = d_neg ? ys : -ys;
    assign y_inc = d_neg ? -xs : xs;
    assign z_inc = d_neg ? atan_w : -atan_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (in_valid)  state_d = ST_ROTATE;
            ST_ROTATE: if (last)      state_d = ST_HOLD;
            ST_HOLD:   if (out_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        cos_d = cos_q;
        sin_d = sin_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d   = X0;
                    y_d   = '0;
                    z_d   = z0;
                    cnt_d = '0;
                    neg_d = fold_hi | fold_lo;
                end
            end
            ST_ROTATE: begin
                if (last) begin
                    cos_d = round_out(x_q, neg_q);
                    sin_d = round_out(y_q, neg_q);
                end else begin
                    x_d   = x_q + x_inc;
                    y_d   = y_q + y_inc;
                    z_d   = z_q + z_inc;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;

endmodule

// File: doc/cordic_sincos_iter.md
CORDIC_SINCOS_ITER -- requirements
Module: cordic_sincos_iter

Interface
REQ-001 Parameter WIDTH, default 22: bit width of the angle and result words; legal range 12..32.
REQ-002 Parameter ITERS, default 20: number of micro-rotations; legal range 8..WIDTH-2.
REQ-003 Parameter GUARD, default 2: extra internal LSBs on the x/y/z datapath.
REQ-004 clk  input  1  rising-edge clock, the only clock in the block.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  angle_in is valid this cycle.
REQ-007 in_ready  output  1  block can accept an angle this cycle.
REQ-008 angle_in  input  WIDTH  signed radians, Q2.(WIDTH-3), legal range [-pi, +pi].
REQ-009 out_valid  output  1  cos_out and sin_out are valid.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 cos_out  output  WIDTH  signed Q1.(WIDTH-2), cos(angle_in).
REQ-012 sin_out  output  WIDTH  signed Q1.(WIDTH-2), sin(angle_in).

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, ROTATE, HOLD.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; all other states SHALL drive in_ready=0.
REQ-015 An input handshake (in_valid & in_ready at a rising edge) SHALL latch the angle and enter ROTATE with iteration counter i=0.
REQ-016 Quadrant fold on accept:
  - angle > +pi/2: z0 = angle - pi, negate flag = 1.
  - angle < -pi/2: z0 = angle + pi, negate flag = 1.
  - otherwise: z0 = angle, negate flag = 0.
REQ-017 Start values on accept: x0 = round(0.6072529350 * 2^(WIDTH-2+GUARD)), y0 = 0.
REQ-018 Each ROTATE cycle SHALL perform one micro-rotation:
  - d = sign(z).
  - x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan(2^-i).
  - >>> is an arithmetic shift; i increments after the rotation.
REQ-019 After ITERS rotations, the FSM SHALL enter HOLD.
REQ-020 On entering HOLD, the outputs SHALL be loaded as follows:
  - Remove GUARD bits by round-half-up.
  - Apply negation if the negate flag is set.
  - Clamp to [-2^(WIDTH-2), +2^(WIDTH-2)].
  - Assert out_valid.
REQ-021 Latency SHALL be exactly ITERS+1 rising edges from the accept edge to the edge that asserts out_valid.
REQ-022 In HOLD, cos_out, sin_out and out_valid SHALL stay stable until out_ready=1.
REQ-023 On the edge where out_valid & out_ready, the FSM SHALL return to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-024 A new angle SHALL NOT be accepted in the same cycle as the output handshake; the minimum issue interval is ITERS+3 cycles.
REQ-025 in_valid while in_ready=0 SHALL be ignored, with no queuing.
REQ-026 Angles with |angle| > pi SHALL produce undefined values but SHALL NOT hang the FSM.
REQ-027 Accuracy: |error| ≤ 4 LSB on each output over [-pi, +pi] for the default parameters.

Reset
REQ-028 reset_n=0 SHALL, asynchronously:
  - force the state to IDLE;
  - clear out_valid, cos_out, sin_out, x, y, z, the counter and the negate flag to 0;
  - set in_ready=1 after reset is released.
REQ-029 Reset asserted mid-ROTATE or in HOLD SHALL discard the operation; no out_valid pulse SHALL follow.

Structure
REQ-030 Package cordic_pkg SHALL hold:
  - the FSM state enum;
  - the PI and PI_HALF constants in Q2 format;
  - the gain constant K;
  - the maximum-iteration constant (32).
REQ-031 Sub-module cordic_atan_rom SHALL map index i to atan(2^-i) in Q2.(WIDTH-3+GUARD); it is combinational and parametrised by WIDTH and GUARD.
REQ-032 The block SHALL use one shared adder/shifter set for x, y and z, with no unrolled stages.

Verification (WIDTH=22, ITERS=20; 1.0 = 1048576)
REQ-033 angle_in=0 -> cos_out=1048576±4, sin_out=0±4, out_valid on the 21st edge after accept.
REQ-034 angle_in=823550 (+pi/2) -> cos_out=0±4, sin_out=1048576±4.
REQ-035 angle_in=-1647099 (-pi, fold path) -> cos_out=-1048576±4, sin_out=0±4.
REQ-036 angle_in=1235324 (3pi/4) -> cos_out=-741455±4, sin_out=741455±4.
REQ-037 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; release -> IDLE the next cycle.
REQ-038 Pulse reset_n low at rotation 7 -> out_valid never asserts, in_ready=1 after release, and the next angle=0 gives the REQ-033 result.
